// File: rtl/fft_pkg.sv
// Shared constants, state encoding and butterfly descriptor type for the radix-2 FFT address path.
package fft_pkg;

  localparam int MAX_N = 1024;

  // Ceiling log2 for elaboration-time constants.
  function automatic int clog2_const(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int ADDR_WIDTH = clog2_const(MAX_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] tw_k;
    logic [ADDR_WIDTH:0]   tw_n;
    logic [3:0]            stage;
    logic                  last;
  } desc_t;

endpackage

// File: rtl/fft_butterfly_agu_if.sv
// Control and descriptor bundle between the FFT AGU (master) and its consumer (slave).
interface fft_butterfly_agu_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH:0]   n_cfg;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [ADDR_WIDTH-1:0] tw_k;
  logic [ADDR_WIDTH:0]   tw_n;
  logic [3:0]            stage;
  logic                  last;

  modport master (
    input  start, n_cfg, out_ready,
    output busy, done, err, out_valid, addr_a, addr_b, tw_k, tw_n, stage, last
  );

  modport slave (
    output start, n_cfg, out_ready,
    input  busy, done, err, out_valid, addr_a, addr_b, tw_k, tw_n, stage, last
  );
endinterface

// File: rtl/fft_bf_addr_map.sv
// Combinational map from (butterfly index, span exponent) to operand addresses and twiddle (k, n).
module fft_bf_addr_map #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-2:0] bf,
  input  logic [3:0]            e,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [ADDR_WIDTH-1:0] tw_k,
  output logic [ADDR_WIDTH:0]   tw_n
);
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH-1:0] h;
  logic [ADDR_WIDTH-1:0] bf_ext;
  logic [ADDR_WIDTH-1:0] j;

  // mask = h-1 and h = 2^e built bitwise, avoiding a barrel shifter.
  for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_span
    assign mask[gi] = (4'(gi) < e);
    assign h[gi]    = (4'(gi) == e);
  end

  assign bf_ext = {1'b0, bf};
  assign j      = bf_ext & mask;
  assign addr_a = ((bf_ext & ~mask) << 1) | j;
  assign addr_b = addr_a | h;
  assign tw_k   = j;
  assign tw_n   = {h, 1'b0};
endmodule

// File: rtl/fft_butterfly_agu.sv
// Radix-2 in-place FFT address generator: walks stages and butterflies, one descriptor per handshake.
// Define FFT_AGU_DIF_EN for decimation-in-frequency ordering (span descending); default is DIT.
module fft_butterfly_agu #(
  parameter int MAX_N      = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  fft_butterfly_agu_if.master bus
);
  import fft_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_FIN  = FIN;
  localparam logic [ADDR_WIDTH:0] N_LIMIT = (ADDR_WIDTH+1)'(MAX_N);

  logic [1:0]            state_reg;
  logic [3:0]            s_reg;
  logic [3:0]            l_m1_reg;
  logic [ADDR_WIDTH-2:0] bf_reg;
  logic [ADDR_WIDTH-2:0] bf_max_reg;
  logic                  gen_done_reg;
  logic                  out_valid_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  err_reg;
  desc_t                 desc_reg;

  logic                  cfg_ok;
  logic [3:0]            l_cfg;
  logic [ADDR_WIDTH-2:0] half_m1;
  logic [3:0]            e;
  logic [ADDR_WIDTH-1:0] map_a;
  logic [ADDR_WIDTH-1:0] map_b;
  logic [ADDR_WIDTH-1:0] map_k;
  logic [ADDR_WIDTH:0]   map_n;
  logic                  final_bf;
  logic                  load;
  logic                  xfer;

  assign cfg_ok = (bus.n_cfg >= (ADDR_WIDTH+1)'(2)) && (bus.n_cfg <= N_LIMIT) &&
                  ((bus.n_cfg & (bus.n_cfg - 1'b1)) == '0);

  always_comb begin
    l_cfg = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      if (bus.n_cfg[i]) l_cfg = 4'(i);
    end
  end

  // N/2-1; for N=MAX_N the truncated difference wraps to all ones, which is the right value.
  assign half_m1 = bus.n_cfg[ADDR_WIDTH-1:1] - 1'b1;

`ifdef FFT_AGU_DIF_EN
  assign e = l_m1_reg - s_reg;
`else
  assign e = s_reg;
`endif

  fft_bf_addr_map #(.ADDR_WIDTH(ADDR_WIDTH)) u_map (
    .bf     (bf_reg),
    .e      (e),
    .addr_a (map_a),
    .addr_b (map_b),
    .tw_k   (map_k),
    .tw_n   (map_n)
  );

  assign final_bf = (s_reg == l_m1_reg) && (bf_reg == bf_max_reg);
  assign xfer     = out_valid_reg && bus.out_ready;
  // Counters always point at the next descriptor to load, so stage wraps cost no bubble.
  assign load     = !gen_done_reg && (!out_valid_reg || bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      s_reg         <= '0;
      l_m1_reg      <= '0;
      bf_reg        <= '0;
      bf_max_reg    <= '0;
      gen_done_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      desc_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              state_reg    <= ST_RUN;
              busy_reg     <= 1'b1;
              s_reg        <= '0;
              bf_reg       <= '0;
              gen_done_reg <= 1'b0;
              l_m1_reg     <= l_cfg - 4'd1;
              bf_max_reg   <= half_m1;
            end else begin
              state_reg <= ST_FIN;
              done_reg  <= 1'b1;
              err_reg   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (load) begin
            desc_reg.addr_a <= map_a;
            desc_reg.addr_b <= map_b;
            desc_reg.tw_k   <= map_k;
            desc_reg.tw_n   <= map_n;
            desc_reg.stage  <= s_reg;
            desc_reg.last   <= final_bf;
            out_valid_reg   <= 1'b1;
            if (final_bf) begin
              gen_done_reg <= 1'b1;
            end else if (bf_reg == bf_max_reg) begin
              bf_reg <= '0;
              s_reg  <= s_reg + 4'd1;
            end else begin
              bf_reg <= bf_reg + 1'b1;
            end
          end else if (xfer) begin
            out_valid_reg <= 1'b0;
          end
          if (xfer && desc_reg.last) begin
            state_reg     <= ST_FIN;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        ST_FIN:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.addr_a    = desc_reg.addr_a;
  assign bus.addr_b    = desc_reg.addr_b;
  assign bus.tw_k      = desc_reg.tw_k;
  assign bus.tw_n      = desc_reg.tw_n;
  assign bus.stage     = desc_reg.stage;
  assign bus.last      = desc_reg.last;
endmodule

// File: doc/fft_butterfly_agu.md
# fft_butterfly_agu

Address-generation unit for the in-place radix-2 FFT engine. For a configured size N (2..MAX_N, power of two) it walks every stage and butterfly and emits, once per accepted transfer, the operand-pair addresses for the data memory and the `(k, n)` index pair consumed directly by the twiddle ROM. It sits directly upstream of the twiddle ROM and the butterfly datapath, gated by a valid/ready handshake.

## Interface
Parameters:
- `MAX_N`, 1024: largest supported FFT size.
- `ADDR_WIDTH`, 10: log2(MAX_N); data-memory and twiddle-index width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a transform; ignored unless IDLE.
- `n_cfg`  in  ADDR_WIDTH+1  FFT size, sampled on accepted `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at end of transform, or on rejected config.
- `err`  out  1  valid with `done`; high when `n_cfg` was invalid.
- `out_valid`  out  1  butterfly descriptor valid.
- `out_ready`  in  1  downstream accepts the descriptor.
- `addr_a`  out  ADDR_WIDTH  upper-wing operand address.
- `addr_b`  out  ADDR_WIDTH  lower-wing operand address.
- `tw_k`  out  ADDR_WIDTH  twiddle index k for the ROM.
- `tw_n`  out  ADDR_WIDTH+1  twiddle size n for the ROM (span m).
- `stage`  out  4  current stage number, 0-based in execution order.
- `last`  out  1  high with the final butterfly of the transform.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: `start`=1 with valid `n_cfg` (power of two, 2 <= n_cfg <= MAX_N) -> RUN, latch N and L=log2(N). Invalid `n_cfg` -> FIN with `err`=1, no descriptors issued.
- RUN: counters `s` (stage, 0..L-1) and `bf` (butterfly, 0..N/2-1). Span exponent e = s (DIT). h = 2^e.
- Descriptor: j = bf & (h-1); `addr_a` = ((bf & ~(h-1)) << 1) | j; `addr_b` = `addr_a` | h; `tw_k` = j; `tw_n` = 2h. Always k < n/2, so the ROM never takes its conjugate or midpoint path.
- Advance on `out_valid && out_ready`: bf+1; at bf = N/2-1 wrap bf to 0 and s+1; at final (s = L-1, bf = N/2-1) -> FIN, `out_valid` drops.
- FIN: `done`=1 one cycle, `err` as determined, -> IDLE.
- `start` while RUN/FIN ignored; `n_cfg` changes after acceptance ignored.
- `rst_n`=0 at any edge, including mid-transform: -> IDLE, all outputs 0, counters cleared; no `done` for the aborted run.

## Timing
- All outputs registered; reset value 0 for every output.
- `start` accepted at edge t -> first descriptor with `out_valid`=1 after edge t+1 (one-cycle latency).
- Throughput one descriptor per cycle while `out_ready`=1; N/2·L descriptors total.
- While `out_valid && !out_ready`: all descriptor fields and `last` held stable; `out_valid` never withdrawn.
- Stage boundaries add no bubble.
- `done` asserts the cycle after the final handshake; `busy` low in that same cycle.
- Invalid config: `done`=`err`=1 one cycle after `start`.

## Configuration
- `FFT_AGU_DIF_EN` defined: decimation-in-frequency ordering, e = L-1-s (span descending, first stage `tw_n`=N); formulas otherwise identical.
- Undefined: DIT ordering, e = s (first stage `tw_n`=2).

## Structure
- Shared package `fft_pkg`: `MAX_N`, `ADDR_WIDTH`, state enum (IDLE/RUN/FIN), a constant log2 function, the descriptor struct (addr_a, addr_b, tw_k, tw_n, stage, last).
- One sub-module: `fft_bf_addr_map`, combinational (bf, e) -> (addr_a, addr_b, tw_k, tw_n); the top holds FSM, counters and output register.

## Test plan
- N=8 DIT, ready high: 12 descriptors; stage 0 (0,1,k0,n2),(2,3,0,2),(4,5,0,2),(6,7,0,2); stage 1 (0,2,0,4),(1,3,1,4),(4,6,0,4),(5,7,1,4); stage 2 (0,4,0,8),(1,5,1,8),(2,6,2,8),(3,7,3,8) with `last`; `done` next cycle.
- N=2: single descriptor (0,1,0,2) with `last`=1, `done` one cycle later.
- N=1024 with random `out_ready`: exactly 5120 handshakes, fields stable under stall, `tw_k` < `tw_n`/2 always.
- `n_cfg`=12, 0, 2048: `done`=`err`=1 after one cycle, `out_valid` never high.
- `rst_n` low mid-stage 2 of N=64: outputs 0 next cycle, no `done`; fresh `start` restarts from (0,1,0,2).
- `FFT_AGU_DIF_EN`, N=8: first descriptor (0,4,0,8), last (6,7,0,2).
